// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, instruction field positions and the
// issue-unit state encoding. Shared with the control unit.
package core_pkg;

  localparam logic [3:0] OP_LDM  = 4'h0;
  localparam logic [3:0] OP_STM  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ADD  = 4'hA;
  localparam logic [3:0] OP_SUB  = 4'hB;
  localparam logic [3:0] OP_DIV  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_ISSUE    = 3'd3,
    S_WAIT_DIV = 3'd4,
    S_HALT     = 3'd5
  } issue_state_t;

  // 1101 and 1110 are the only unassigned encodings.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/instr_issue_unit_decode.sv
// Combinational split of an instruction word into register fields plus
// the class flags the issue FSM branches on.
module instr_field_decode
  import core_pkg::*;
#(
  parameter int INST_W = 16
) (
  input  logic [INST_W-1:0] inst,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic              is_div,
  output logic              is_halt,
  output logic              is_illegal
);

  always_comb begin
    opcode     = inst[OPC_MSB:OPC_LSB];
    rd         = inst[RD_MSB:RD_LSB];
    rs1        = inst[RS1_MSB:RS1_LSB];
    rs2        = inst[RS2_MSB:RS2_LSB];
    is_div     = (opcode == OP_DIV);
    is_halt    = (opcode == OP_HALT);
    is_illegal = op_is_illegal(opcode);
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction fetch/issue front end: fetches, splits and issues one word at a
// time, holding on stall/divide and stopping on HALT. Macro ILLEGAL_TRAP_EN.
module instr_issue_unit
  import core_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_data,
  input  logic              stall,
  input  logic              div_done,
  output logic              issue_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  issue_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [3:0]        opc_q, rd_q, rs1_q, rs2_q;
  logic              div_q, halted_q, req_q, vld_q;
  logic              pc_inc, ld_fields, set_halt;

  logic [3:0] dec_opc, dec_rd, dec_rs1, dec_rs2;
  logic       dec_div, dec_halt, dec_illegal;

  instr_field_decode #(.INST_W(INST_W)) u_dec (
    .inst       (imem_data),
    .opcode     (dec_opc),
    .rd         (dec_rd),
    .rs1        (dec_rs1),
    .rs2        (dec_rs2),
    .is_div     (dec_div),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

`ifdef ILLEGAL_TRAP_EN
  logic set_ill, illegal_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_inc    = 1'b0;
    ld_fields = 1'b0;
    set_halt  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    set_ill   = 1'b0;
`endif
    case (state_q)
      S_IDLE:     if (start) state_d = S_FETCH;
      S_FETCH:    state_d = S_WAIT_MEM;
      S_WAIT_MEM: begin
        if (imem_valid) begin
          ld_fields = 1'b1;
          if (dec_halt) begin
            state_d  = S_HALT;
            set_halt = 1'b1;
          end else if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            state_d  = S_HALT;
            set_halt = 1'b1;
            set_ill  = 1'b1;
`else
            // Unassigned opcodes retire silently as NOPs.
            state_d  = S_FETCH;
            pc_inc   = 1'b1;
`endif
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_inc  = 1'b1;
          state_d = div_q ? S_WAIT_DIV : S_FETCH;
        end
      end
      S_WAIT_DIV: if (div_done) state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      opc_q    <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      div_q    <= 1'b0;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      // Strobes come straight from flops, one per state, so they never overlap.
      req_q   <= (state_d == S_FETCH);
      vld_q   <= (state_d == S_ISSUE);
      if (pc_inc) pc_q <= pc_q + ADDR_W'(1);
      if (ld_fields) begin
        opc_q <= dec_opc;
        rd_q  <= dec_rd;
        rs1_q <= dec_rs1;
        rs2_q <= dec_rs2;
        div_q <= dec_div;
      end
      if (set_halt) halted_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          illegal_q <= 1'b0;
    else if (set_ill) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign issue_valid = vld_q;
  assign opcode      = opc_q;
  assign rd          = rd_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign pc          = pc_q;
  assign halted      = halted_q;

endmodule
